// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin output-mux arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, wrapping.
module rr_pick #(
   parameter int N_REQ = 3,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic             any,
   output logic [IW-1:0]    idx
);

   logic [2*N_REQ-1:0] dbl;

   assign dbl = {req, req};
   assign any = |req;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      int pos;
      pos = 0;
      idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         pos = int'(last) + k;
         if (dbl[pos]) begin
            idx = (pos >= N_REQ) ? IW'(pos - N_REQ) : IW'(pos);
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered output between N_REQ requesters.
// Optional checkers compiled in when ARB_ONEHOT_CHECK_EN is defined.
module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ     = 3,
   parameter int DW        = 8,
   parameter int MAX_BURST = ARB_MAX_BURST
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [DW-1:0]            data [N_REQ],
   output logic [N_REQ-1:0]         gnt,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   output logic [$clog2(N_REQ)-1:0] out_src,
   input  logic                     out_ready
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);

   arb_state_t    state, state_next;
   logic [IW-1:0] owner, owner_next;
   logic [IW-1:0] last, last_next;
   logic [BW-1:0] beats, beats_next, beats_inc;
   logic          valid_next;
   logic [DW-1:0] data_next;
   logic [IW-1:0] src_next;
   logic          accept;
   logic          pick_any;
   logic [IW-1:0] pick_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req  (req),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign beats_inc = beats + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= IW'(N_REQ - 1);
         beats     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else begin
         state     <= state_next;
         owner     <= owner_next;
         last      <= last_next;
         beats     <= beats_next;
         out_valid <= valid_next;
         out_data  <= data_next;
         out_src   <= src_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      last_next  = last;
      beats_next = beats;
      valid_next = out_valid;
      data_next  = out_data;
      src_next   = out_src;
      gnt        = '0;
      accept     = 1'b0;

      // A new beat below overrides this consume-clear.
      if (out_valid && out_ready) begin
         valid_next = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (pick_any) begin
               owner_next = pick_idx;
               beats_next = '0;
               state_next = GRANT;
            end
         end
         GRANT: begin
            accept     = req[owner] && (!out_valid || out_ready);
            gnt[owner] = accept;
            if (!req[owner]) begin
               state_next = IDLE;
               last_next  = owner;
            end else if (accept) begin
               valid_next = 1'b1;
               data_next  = data[owner];
               src_next   = owner;
               beats_next = beats_inc;
               if (beats_inc == BURST_LAST) begin
                  state_next = IDLE;
                  last_next  = owner;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef ARB_ONEHOT_CHECK_EN
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt))
      else $error("gnt not onehot0: %b", gnt);

   a_gnt_in_grant: assert property (@(posedge clk) disable iff (!rst_n)
      (gnt != '0) |-> (state == GRANT))
      else $error("gnt asserted outside GRANT");

   a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src)))
      else $error("output changed while stalled");

   a_beats_bound: assert property (@(posedge clk) disable iff (!rst_n)
      beats <= BURST_LAST)
      else $error("beats exceeded burst limit: %0d", beats);
`else
   // Checkers compiled out; datapath identical.
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios push expected beats, a monitor pops them.
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic [7:0] data [3];
   logic [2:0] gnt;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_src;
   logic       out_ready;

   int vectors = 0;
   int errors  = 0;
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   rr_mux_arbiter #(
      .N_REQ     (3),
      .DW        (8),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h at %0t", name, act, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [7:0] d, input int n);
      repeat (n) exp_q.push_back({s, d});
   endtask

   // Monitor: a beat transfers at the next edge whenever valid && ready.
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_beat: got src=%0d data=%0h, expected none at %0t",
                        out_src, out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("beat", {22'd0, out_src, out_data}, {22'd0, e});
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) data[i] = '0;

      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_out_src",   {30'd0, out_src},   32'd0);
      chk("rst_gnt",       {29'd0, gnt},       32'd0);
      tick(2);
      rst_n = 1'b1;

      // Single requester: two bursts of four with one bubble between.
      push(2'd0, 8'd1, 8);
      req     = 3'b001;
      data[0] = 8'd1;
      chk("s1_idle_gnt", {29'd0, gnt}, 32'd0);
      tick(1);
      chk("s1_first_gnt", {29'd0, gnt}, 32'd1);
      tick(1);
      chk("s1_valid_lat", {31'd0, out_valid}, 32'd1);
      chk("s1_data", {24'd0, out_data}, 32'd1);
      tick(3);
      chk("s1_release_gnt", {29'd0, gnt}, 32'd0);
      chk("s1_last_beat_valid", {31'd0, out_valid}, 32'd1);
      tick(1);
      chk("s1_bubble", {31'd0, out_valid}, 32'd0);
      chk("s1_regrant", {29'd0, gnt}, 32'd1);
      tick(1);
      chk("s1_second_burst", {31'd0, out_valid}, 32'd1);
      tick(3);
      req = 3'b000;
      tick(3);

      // Reset mid-burst: second beat is discarded.
      push(2'd0, 8'd5, 1);
      req     = 3'b001;
      data[0] = 8'd5;
      tick(3);
      chk("s5_beat2_valid", {31'd0, out_valid}, 32'd1);
      chk("s5_beat2_data", {24'd0, out_data}, 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s5_async_valid", {31'd0, out_valid}, 32'd0);
      chk("s5_async_data",  {24'd0, out_data},  32'd0);
      chk("s5_async_gnt",   {29'd0, gnt},       32'd0);
      req = 3'b000;
      tick(2);
      rst_n = 1'b1;

      // All requesting from fresh reset: 0,1,2,0 bursts.
      push(2'd0, 8'd1, 4);
      push(2'd1, 8'd2, 4);
      push(2'd2, 8'd3, 4);
      push(2'd0, 8'd1, 4);
      data[0] = 8'd1;
      data[1] = 8'd2;
      data[2] = 8'd3;
      req     = 3'b111;
      tick(1);
      chk("s2_gnt_r0", {29'd0, gnt}, 32'd1);
      tick(5);
      chk("s2_gnt_r1", {29'd0, gnt}, 32'd2);
      tick(5);
      chk("s2_gnt_r2", {29'd0, gnt}, 32'd4);
      tick(5);
      chk("s2_gnt_r0_again", {29'd0, gnt}, 32'd1);
      tick(4);
      req = 3'b000;
      tick(3);

      // Early drop: requester 1 leaves after two beats, requester 2 takes over.
      push(2'd1, 8'h22, 2);
      push(2'd2, 8'h33, 4);
      data[1] = 8'h22;
      data[2] = 8'h33;
      req     = 3'b110;
      tick(3);
      req = 3'b100;
      tick(2);
      chk("s3_gnt_r2", {29'd0, gnt}, 32'd4);
      tick(4);
      req = 3'b000;
      tick(3);

      // Stall for five edges mid-burst: output held, no beat lost.
      push(2'd0, 8'h41, 1);
      push(2'd0, 8'h42, 1);
      push(2'd0, 8'h43, 1);
      push(2'd0, 8'h44, 1);
      data[0] = 8'h41;
      req     = 3'b001;
      tick(2);
      data[0] = 8'h42;
      tick(1);
      data[0]   = 8'h43;
      out_ready = 1'b0;
      tick(1);
      chk("s4_stall_gnt",  {29'd0, gnt},      32'd0);
      chk("s4_stall_data", {24'd0, out_data}, 32'h42);
      tick(4);
      chk("s4_held_data",  {24'd0, out_data}, 32'h42);
      chk("s4_held_src",   {30'd0, out_src},  32'd0);
      chk("s4_held_gnt",   {29'd0, gnt},      32'd0);
      out_ready = 1'b1;
      tick(1);
      data[0] = 8'h44;
      tick(1);
      req = 3'b000;
      tick(3);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer for the shared 8-bit result mux: it shares one registered output between N requesters, each offering a data byte under a req/gnt handshake. Ownership is granted one requester at a time and held for a bounded burst. The block replaces the ad-hoc priority `unique if` selection with a fair, registered, provably one-hot select, and sits between the requester datapaths and the downstream consumer.

## Interface
- `N_REQ`, 3: number of requesters; legal range 2 to 8.
- `DW`, 8: data width.
- `MAX_BURST`, 4: maximum beats per grant; minimum 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request; requester i's data is valid while `req[i]`=1.
- `data` in N_REQ×DW: unpacked array, one byte per requester.
- `gnt` out N_REQ: per-requester accept strobe; a beat transfers from i when `req[i] && gnt[i]`.
- `out_valid` out 1: registered output valid.
- `out_data` out DW: registered output data.
- `out_src` out $clog2(N_REQ): index of the requester that produced `out_data`.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.

## Operation
- FSM states `IDLE`, `GRANT`. Registers: `owner`, `last` (previous owner), `beats` ($clog2(MAX_BURST+1) bits).
- `IDLE`: if any `req`, pick the first requester with `req` set, searching from `last+1` modulo N_REQ and wrapping. Load `owner`, clear `beats`, go to `GRANT`. If no `req`, stay in `IDLE`.
- `GRANT`: `gnt[owner] = req[owner] && (!out_valid || out_ready)`. All other `gnt` bits are 0. `gnt` is combinational from state, `req` and `out_*`.
- On an accepted beat: `out_data <= data[owner]`, `out_src <= owner`, `out_valid <= 1`, `beats <= beats+1`.
- Release to `IDLE` with `last <= owner` when either condition holds:
  - an accepted beat makes `beats` reach MAX_BURST, or
  - `req[owner]` is 0 in `GRANT`. A drop without any beat still releases.
- `out_valid` clears when the output is consumed (`out_valid && out_ready`) and no new beat is accepted in the same cycle. Consume and accept in the same cycle is legal; `out_valid` stays 1.
- Downstream stall (`out_ready`=0 with `out_valid`=1): `gnt` is 0, `out_*` is held stable, `beats` does not advance, and the grant is retained.
- Simultaneous requests: only the round-robin pick matters. Requester index order gives no priority beyond the pointer.
- Reset mid-burst: all state is cleared immediately. The in-flight output byte is discarded.

## Timing
- Reset values:
  - `state` = `IDLE`
  - `owner` = 0
  - `last` = N_REQ−1, so that the first pick starts at requester 0
  - `beats` = 0
  - `gnt` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0
- Latency, with `req` rising at edge k while in `IDLE`:
  - `GRANT` is entered at edge k+1.
  - The first beat is accepted in cycle k+1.
  - `out_valid` is 1 after edge k+2.
- Back-to-back beats stream at 1 per cycle while `out_ready`=1.
- Handover costs exactly one `IDLE` bubble cycle between bursts.
- Worst-case wait for a continuously requesting requester: (N_REQ−1)×(MAX_BURST+1) cycles plus downstream stalls.

## Configuration
- `ARB_ONEHOT_CHECK_EN` defined: compiles in concurrent assertions, each reported with `$error`:
  - `gnt` is $onehot0 every cycle;
  - `gnt` is nonzero only in `GRANT`;
  - `out_data`/`out_src` are stable while `out_valid && !out_ready`;
  - `beats` never exceeds MAX_BURST.
- Not defined: no checkers. RTL behaviour is identical either way.

## Structure
- Package `arb_pkg`: `arb_state_t` enum (`IDLE`, `GRANT`) and the default `MAX_BURST` constant.
- Sub-module `rr_pick`: a combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: `any`, `idx`.
  - Implemented with a doubled request vector and a first-one search.
- Everything else lives in `rr_mux_arbiter`.

## Test plan
All cases use N_REQ=3, DW=8, MAX_BURST=4.
- Reset then single requester: `req`=3'b001, `data[0]`=8'd1, `out_ready`=1 → `out_valid`=1 at the 2nd edge after `req`; out stream 1,1,1,1, then one bubble, then a new grant to requester 0.
- All requesting: `req`=3'b111, data 1/2/3, `out_ready`=1 → `out_src` sequence 0×4, 1×4, 2×4, 0×4…, with one bubble between owners.
- Early drop: requester 1 drops `req` after 2 beats while `req[2]`=1 → exactly 2 beats of `data[1]`, then requester 2 is granted.
- Stall: `out_ready`=0 for 5 cycles mid-burst → `gnt`=0, `out_data` and `out_src` held; the burst resumes with the remaining beats and no loss.
- Reset mid-burst: drive `rst_n`=0 asynchronously during beat 2 → all outputs go to 0 immediately; after release, requester 0 is picked first.
- With `ARB_ONEHOT_CHECK_EN` defined, all the above run with zero assertion failures.
